// File: rtl/uart_rx_oversample_if.sv
// Receive-side result bus of the UART RX core.
// The core drives it through master; the RX FIFO write port or a bench reads it through slave.
interface uart_rx_oversample_if;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_error_o;
  logic       parity_error_o;

  modport master (
    output data_o,
    output data_valid_o,
    output frame_error_o,
    output parity_error_o
  );

  modport slave (
    input data_o,
    input data_valid_o,
    input frame_error_o,
    input parity_error_o
  );
endinterface

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver with an 8-bit LSB-first frame, optional parity and one stop bit.
// Results leave as one-cycle pulses on the interface bus.
module uart_rx_oversample #(
  parameter int unsigned ClkFreq        = 50_000_000,
  parameter int unsigned BaudRate       = 115_200,
  parameter int unsigned OversampleRate = 16,
  parameter string       ParityBit      = "none",
  parameter bit          UseDebouncer   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 uart_rxd_i,
  uart_rx_oversample_if.master rx_bus
);

  localparam int unsigned Div       = ClkFreq / (BaudRate * OversampleRate);
  localparam int unsigned TickW     = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned SampW     = $clog2(OversampleRate);
  localparam int unsigned HalfOs    = OversampleRate / 2;
  localparam bit          ParityEn  = (ParityBit != "none");
  localparam bit          ParityOdd = (ParityBit == "odd");

  if (Div < 1) begin : g_div_chk
    $error("uart_rx_oversample: ClkFreq too low for BaudRate*OversampleRate");
  end
  if ((OversampleRate < 4) || (OversampleRate % 2 != 0)) begin : g_os_chk
    $error("uart_rx_oversample: OversampleRate must be even and >= 4");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         sync_q;
  logic [2:0]         deb_q;
  logic [TickW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [SampW-1:0]   samp_q, samp_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               perr_q, perr_d;
  logic [7:0]         data_q, data_d;
  logic               dv_q, dv_d;
  logic               fe_q, fe_d;
  logic               pe_q, pe_d;

  logic               maj_c;
  logic               rx_filt_c;
  logic               tick_c;
  logic [SampW-1:0]   samp_end_c;
  logic               sample_c;

  // Two-flop synchronizer followed by a 3-deep history for the majority filter
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= 2'b11;
      deb_q  <= 3'b111;
    end else begin
      sync_q <= {sync_q[0], uart_rxd_i};
      deb_q  <= {deb_q[1:0], sync_q[1]};
    end
  end

  assign maj_c     = (deb_q[0] & deb_q[1]) | (deb_q[0] & deb_q[2]) | (deb_q[1] & deb_q[2]);
  assign rx_filt_c = UseDebouncer ? maj_c : sync_q[1];

  assign tick_c     = (tick_cnt_q == TickW'(Div - 1));
  // START samples after half a bit, every other state at the end of a full bit
  assign samp_end_c = (state_q == START) ? SampW'(HalfOs - 1) : SampW'(OversampleRate - 1);
  assign sample_c   = tick_c && (samp_q == samp_end_c);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
      pe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      fe_q       <= fe_d;
      pe_q       <= pe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TickW'(1);
    samp_d     = samp_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
    pe_d       = 1'b0;

    if (tick_c) begin
      samp_d = sample_c ? '0 : samp_q + SampW'(1);
    end

    unique case (state_q)
      IDLE: begin
        samp_d = '0;
        bit_d  = '0;
        perr_d = 1'b0;
        if (!rx_filt_c) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (sample_c) begin
          state_d = rx_filt_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample_c) begin
          shift_d = {rx_filt_c, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ParityEn ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (sample_c) begin
          perr_d  = ((^shift_q) ^ rx_filt_c) != ParityOdd;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_c) begin
          if (rx_filt_c) begin
            dv_d    = 1'b1;
            data_d  = shift_q;
            pe_d    = ParityEn && perr_q;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_filt_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_bus.data_o         = data_q;
  assign rx_bus.data_valid_o   = dv_q;
  assign rx_bus.frame_error_o  = fe_q;
  assign rx_bus.parity_error_o = pe_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Scoreboard bench for uart_rx_oversample: one instance without parity, one with even parity.
module tb_uart_rx_oversample;

  localparam int BitCyc = 32;

  typedef struct {
    bit         is_fe;
    logic [7:0] data;
    bit         perr;
    int         gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic rxd_n = 1'b1;
  logic rxd_e = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t       q_n[$];
  exp_t       q_e[$];
  logic [7:0] last_n = 8'h00;
  logic [7:0] last_e = 8'h00;
  int         lastv_n = 0;
  int         lastv_e = 0;

  uart_rx_oversample_if if_n ();
  uart_rx_oversample_if if_e ();

  uart_rx_oversample #(
    .ClkFreq(32_000_000), .BaudRate(1_000_000), .OversampleRate(16),
    .ParityBit("none"), .UseDebouncer(1'b1)
  ) dut_n (
    .clk_i(clk), .reset_i(reset_i), .uart_rxd_i(rxd_n), .rx_bus(if_n)
  );

  uart_rx_oversample #(
    .ClkFreq(32_000_000), .BaudRate(1_000_000), .OversampleRate(16),
    .ParityBit("even"), .UseDebouncer(1'b1)
  ) dut_e (
    .clk_i(clk), .reset_i(reset_i), .uart_rxd_i(rxd_e), .rx_bus(if_e)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic mon(input bit sel, input logic dv, input logic fe, input logic pe,
                     input logic [7:0] d);
    exp_t e;
    int   sz;
    if (dv && fe) check_eq(sel ? "excl_e" : "excl_n", 32'(1), 32'(0));
    if (pe && !dv) check_eq(sel ? "pe_alone_e" : "pe_alone_n", 32'(1), 32'(0));
    if (dv || fe) begin
      sz = sel ? q_e.size() : q_n.size();
      if (sz == 0) begin
        check_eq(sel ? "unexpected_e" : "unexpected_n", {29'd0, dv, fe, pe}, 32'(0));
      end else begin
        e = sel ? q_e.pop_front() : q_n.pop_front();
        check_eq(sel ? "kind_e" : "kind_n", 32'(fe), 32'(e.is_fe));
        check_eq(sel ? "data_e" : "data_n", 32'(d), 32'(e.data));
        check_eq(sel ? "perr_e" : "perr_n", 32'(pe), 32'(e.perr));
        if (e.gap != 0)
          check_eq(sel ? "gap_e" : "gap_n", 32'(cyc - (sel ? lastv_e : lastv_n)), 32'(e.gap));
      end
      if (dv) begin
        if (sel) lastv_e = cyc; else lastv_n = cyc;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      mon(1'b0, if_n.data_valid_o, if_n.frame_error_o, if_n.parity_error_o, if_n.data_o);
      mon(1'b1, if_e.data_valid_o, if_e.frame_error_o, if_e.parity_error_o, if_e.data_o);
    end
  end

  task automatic expect_data(input bit sel, input logic [7:0] b, input bit perr, input int gap);
    exp_t e;
    e.is_fe = 1'b0; e.data = b; e.perr = perr; e.gap = gap;
    if (sel) begin q_e.push_back(e); last_e = b; end
    else begin q_n.push_back(e); last_n = b; end
  endtask

  task automatic expect_fe(input bit sel);
    exp_t e;
    e.is_fe = 1'b1; e.data = sel ? last_e : last_n; e.perr = 1'b0; e.gap = 0;
    if (sel) q_e.push_back(e); else q_n.push_back(e);
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int ncyc);
    if (sel) rxd_e = v; else rxd_n = v;
    repeat (ncyc) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input bit par_en,
                            input bit par_val, input bit stop_val);
    logic [7:0] bb;
    bb = b;
    drive_bit(sel, 1'b0, BitCyc);
    for (int i = 0; i < 8; i++) drive_bit(sel, bb[i], BitCyc);
    if (par_en) drive_bit(sel, par_val, BitCyc);
    drive_bit(sel, stop_val, BitCyc);
    if (sel) rxd_e = 1'b1; else rxd_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (((q_n.size() != 0) || (q_e.size() != 0)) && (n < 1000)) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_n", 32'(q_n.size()), 32'(0));
    check_eq("drain_e", 32'(q_e.size()), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ab;
    repeat (4) @(negedge clk);
    check_eq("rst_data_n", 32'(if_n.data_o), 32'(0));
    check_eq("rst_dv_n", 32'(if_n.data_valid_o), 32'(0));
    check_eq("rst_fe_n", 32'(if_n.frame_error_o), 32'(0));
    check_eq("rst_pe_n", 32'(if_n.parity_error_o), 32'(0));
    check_eq("rst_data_e", 32'(if_e.data_o), 32'(0));
    check_eq("rst_dv_e", 32'(if_e.data_valid_o), 32'(0));
    check_eq("rst_fe_e", 32'(if_e.frame_error_o), 32'(0));
    check_eq("rst_pe_e", 32'(if_e.parity_error_o), 32'(0));
    reset_i = 1'b0;
    repeat (2 * BitCyc) @(negedge clk);

    // Basic frame, no parity
    expect_data(1'b0, 8'hA5, 1'b0, 0);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    drain();

    // Even parity: correct, then wrong parity bit
    expect_data(1'b1, 8'h03, 1'b0, 0);
    send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
    expect_data(1'b1, 8'h03, 1'b1, 0);
    send_frame(1'b1, 8'h03, 1'b1, 1'b1, 1'b1);
    drain();

    // Low stop bit followed by a long break, then a clean frame
    expect_fe(1'b0);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 40 * BitCyc);
    drive_bit(1'b0, 1'b1, 2 * BitCyc);
    check_eq("break_q_n", 32'(q_n.size()), 32'(0));
    expect_data(1'b0, 8'h0F, 1'b0, 0);
    send_frame(1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
    drain();

    // Single-cycle glitch and a short false start produce nothing
    drive_bit(1'b0, 1'b0, 1);
    drive_bit(1'b0, 1'b1, 2 * BitCyc);
    drive_bit(1'b0, 1'b0, 8);
    drive_bit(1'b0, 1'b1, 2 * BitCyc);
    check_eq("false_start_data", 32'(if_n.data_o), 32'(8'h0F));
    expect_data(1'b0, 8'h80, 1'b0, 0);
    send_frame(1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-to-back frames with no idle gap
    expect_data(1'b0, 8'hFF, 1'b0, 0);
    expect_data(1'b0, 8'h00, 1'b0, 10 * BitCyc);
    expect_data(1'b0, 8'h3C, 1'b0, 10 * BitCyc);
    send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drain();

    // Reset in the middle of data bit 4 of an in-flight frame
    ab = 8'h33;
    drive_bit(1'b0, 1'b0, BitCyc);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, ab[i], BitCyc);
    drive_bit(1'b0, ab[4], BitCyc / 2);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    last_n = 8'h00;
    last_e = 8'h00;
    check_eq("midrst_data_n", 32'(if_n.data_o), 32'(0));
    check_eq("midrst_dv_n", 32'(if_n.data_valid_o), 32'(0));
    check_eq("midrst_data_e", 32'(if_e.data_o), 32'(0));
    drive_bit(1'b0, 1'b1, 12 * BitCyc);
    expect_data(1'b0, 8'h5A, 1'b0, 0);
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    drain();
    repeat (2 * BitCyc) @(negedge clk);
    check_eq("final_data_n", 32'(if_n.data_o), 32'(8'h5A));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
